// File: rtl/mul_18x18_seq_if.sv
// Operand/result handshake bundle for the 18x18 sequential multiplier.
// Both sides use the same valid/ready rule: a transfer happens on a rising edge
// where valid and ready are both high. The producer holds valid and its data
// stable until then, and ready may depend on state but never on valid.
interface mul_18x18_seq_if;
  logic        i_valid;
  logic        o_ready;
  logic [17:0] i_a;
  logic [17:0] i_b;
  logic        o_valid;
  logic        i_ready;
  logic [35:0] o_product;
  logic        o_busy;

  modport slave (
    input  i_valid, i_a, i_b, i_ready,
    output o_ready, o_valid, o_product, o_busy
  );

  modport master (
    output i_valid, i_a, i_b, i_ready,
    input  o_ready, o_valid, o_product, o_busy
  );
endinterface

// File: rtl/mul_18x18_seq.sv
// Shift-and-add unsigned 18x18 multiplier. One 36-bit ripple adder is reused
// once per cycle over exactly 18 iterations; the result waits in DONE until taken.

module add_36bits (
  input  logic [35:0] i_a,
  input  logic [35:0] i_b,
  input  logic        i_carry,
  output logic [35:0] o_data,
  output logic        o_carry
);
  logic [36:0] c;

  always_comb begin
    c      = '0;
    o_data = '0;
    c[0]   = i_carry;
    for (int i = 0; i < 36; i++) begin
      o_data[i] = i_a[i] ^ i_b[i] ^ c[i];
      c[i+1]    = (i_a[i] & i_b[i]) | (c[i] & (i_a[i] ^ i_b[i]));
    end
    o_carry = c[36];
  end
endmodule

module mul_18x18_seq (
  input  logic           i_clk,
  input  logic           i_rst,
  mul_18x18_seq_if.slave bus,
  output logic [1:0]     dbg_state,
  output logic           dbg_carry
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  logic [35:0] mcand;
  logic [35:0] acc;
  logic [17:0] mplier;
  logic [4:0]  cnt;
  logic [35:0] sum;
  logic        add_carry;
  logic        add_en;
  logic [35:0] acc_next;
  logic        valid_q;
  logic        busy_q;
  logic [35:0] product_q;

  add_36bits u_add (
    .i_a    (acc),
    .i_b    (mcand),
    .i_carry(1'b0),
    .o_data (sum),
    .o_carry(add_carry)
  );

  assign add_en   = (state == CALC) & mplier[0];
  assign acc_next = add_en ? sum : acc;

  // Carry out can never be set for an 18x18 product; exposed only for checking.
  assign dbg_carry = add_carry & add_en;
  assign dbg_state = state;

  assign bus.o_ready   = (state == IDLE) & ~i_rst;
  assign bus.o_valid   = valid_q;
  assign bus.o_busy    = busy_q;
  assign bus.o_product = product_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= IDLE;
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      cnt       <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      product_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.i_valid) begin
            mcand  <= {18'b0, bus.i_a};
            mplier <= bus.i_b;
            acc    <= '0;
            cnt    <= '0;
            state  <= CALC;
            busy_q <= 1'b1;
          end
        end
        CALC: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 5'd1;
          // The 18th iteration is folded into the product register directly.
          if (cnt == 5'd17) begin
            state     <= DONE;
            busy_q    <= 1'b0;
            valid_q   <= 1'b1;
            product_q <= acc_next;
          end
        end
        DONE: begin
          if (bus.i_ready) begin
            state   <= IDLE;
            valid_q <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mul_18x18_seq.sv
// Directed bench for mul_18x18_seq: hand-computed products, latency, backpressure,
// ignored requests while busy, and reset in the middle of a calculation.
module tb_mul_18x18_seq;
  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;
  logic       dbg_carry;

  mul_18x18_seq_if bus ();

  mul_18x18_seq dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .bus      (bus),
    .dbg_state(dbg_state),
    .dbg_carry(dbg_carry)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_bad    = 0;
  logic [35:0] exp_q[$];

  task automatic check(input string tag, input logic [35:0] got, input logic [35:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operand pair and collect its result. hold = cycles of i_ready low
  // after o_valid; poke = drive bogus requests while CALC and DONE are active.
  task automatic run_op(input logic [17:0] a, input logic [17:0] b,
                        input logic [35:0] exp, input int hold, input bit poke);
    int t;
    int edges;
    logic [35:0] want;
    exp_q.push_back(exp);
    bus.i_ready = (hold == 0);
    t = 0;
    while (!bus.o_ready && t < 50) begin
      tick();
      t++;
    end
    if (!bus.o_ready) check("ready_timeout", 36'(bus.o_ready), 36'd1);
    bus.i_valid = 1'b1;
    bus.i_a     = a;
    bus.i_b     = b;
    tick();
    bus.i_valid = 1'b0;
    bus.i_a     = 18'($urandom_range(0, 18'h3FFFF));
    bus.i_b     = 18'($urandom_range(0, 18'h3FFFF));
    edges = 0;
    while (!bus.o_valid && edges < 40) begin
      if (bus.o_busy) check("carry", 36'(dbg_carry), 36'd0);
      if (poke && edges == 5) bus.i_valid = 1'b1;
      tick();
      edges++;
    end
    want = exp_q.pop_front();
    check("latency", 36'(edges), 36'd18);
    check("product", bus.o_product, want);
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        tick();
        check("hold_valid", 36'(bus.o_valid), 36'd1);
        check("hold_product", bus.o_product, want);
        check("hold_ready", 36'(bus.o_ready), 36'd0);
      end
      bus.i_valid = 1'b0;
      bus.i_ready = 1'b1;
    end
    bus.i_valid = 1'b0;
    tick();
    check("consumed_valid", 36'(bus.o_valid), 36'd0);
    check("consumed_ready", 36'(bus.o_ready), 36'd1);
    if (hold > 0) begin
      tick();
      check("single_handshake", 36'(bus.o_valid), 36'd0);
      check("stay_idle", 36'(bus.o_busy), 36'd0);
    end
  endtask

  initial begin
    rst         = 1'b1;
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b1;
    bus.i_a     = '0;
    bus.i_b     = '0;
    tick();
    check("rst_ready", 36'(bus.o_ready), 36'd0);
    check("rst_valid", 36'(bus.o_valid), 36'd0);
    check("rst_busy", 36'(bus.o_busy), 36'd0);
    check("rst_product", bus.o_product, 36'd0);
    check("rst_state", 36'(dbg_state), 36'd0);
    tick();
    rst = 1'b0;
    tick();
    check("post_rst_ready", 36'(bus.o_ready), 36'd1);

    run_op(18'd5, 18'd7, 36'h000000023, 0, 1'b0);
    run_op(18'h3FFFF, 18'h3FFFF, 36'hFFFF80001, 0, 1'b0);
    run_op(18'h00000, 18'h2AAAA, 36'h000000000, 0, 1'b0);
    run_op(18'h12345, 18'h00000, 36'h000000000, 0, 1'b0);
    run_op(18'h12345, 18'h00100, 36'h001234500, 5, 1'b0);
    run_op(18'h00ABC, 18'h00010, 36'h00000ABC0, 3, 1'b1);
    run_op(18'h00001, 18'h20000, 36'h000020000, 0, 1'b0);

    // reset partway through an operation
    bus.i_ready = 1'b1;
    bus.i_valid = 1'b1;
    bus.i_a     = 18'h12345;
    bus.i_b     = 18'h3;
    tick();
    bus.i_valid = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    check("mid_busy", 36'(bus.o_busy), 36'd1);
    rst = 1'b1;
    #1;
    check("arst_busy", 36'(bus.o_busy), 36'd0);
    check("arst_valid", 36'(bus.o_valid), 36'd0);
    check("arst_product", bus.o_product, 36'd0);
    check("arst_ready", 36'(bus.o_ready), 36'd0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.o_valid) check("dropped_op_valid", 36'(bus.o_valid), 36'd0);
    end
    check("after_rst_state", 36'(dbg_state), 36'd0);
    run_op(18'd3, 18'd3, 36'h000000009, 0, 1'b0);

    check("queue_empty", 36'(exp_q.size()), 36'd0);
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
